// File: rtl/pulse_blinker_pkg.sv
// -----------------------------------------------------------------------------
// pulse_blinker_pkg
// Shared types and helpers for the pulse_blinker block.
//   blink_state_t : FSM state encoding (IDLE, ON, GAP)
//   calc_cbits    : phase-counter width, $clog2 of the longer phase, minimum 1
// -----------------------------------------------------------------------------
package pulse_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_t;

  // The counter only has to reach (cycles-1), so $clog2 of the longer phase
  // is enough; a 1-cycle phase would give 0 bits, hence the floor of 1.
  function automatic int calc_cbits(input int on_c, input int gap_c);
    int m;
    int w;
    m = (on_c > gap_c) ? on_c : gap_c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_blinker_blink_timer.sv
// -----------------------------------------------------------------------------
// blink_timer
// Phase counter for pulse_blinker. Counts up by one per cycle from 0 and is
// forced back to 0 by clear. expire is combinational: high while count == limit.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clear     : load 0 on the next edge (has priority over counting)
//   limit     : terminal count for the current phase
//   expire    : count equals limit this cycle
// -----------------------------------------------------------------------------
module blink_timer #(
  parameter int cbits = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [cbits-1:0] limit,
  output logic             expire
);

  logic [cbits-1:0] count_q;
  logic [cbits-1:0] count_d;

  always_comb begin
    count_d = count_q + cbits'(1);
    if (clear) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = (count_q == limit);

endmodule

// File: rtl/pulse_blinker.sv
// -----------------------------------------------------------------------------
// pulse_blinker
// Turns single-cycle event strobes into visible LED blinks: on for on_cycles,
// then off for gap_cycles. Events arriving during a blink are queued in a
// saturating pending counter and replayed back-to-back with no IDLE cycle.
//
// Optional feature: define PULSE_BLINKER_OVERFLOW_EN to get a sticky
// o_overflow flag for dropped events; otherwise o_overflow is tied to 0.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_pulse      : event strobe, every high cycle is one event
//   o_led        : registered LED drive (active_value while on)
//   o_busy       : registered, high while the FSM is ON or GAP
//   o_pending    : number of queued blinks
//   o_overflow   : sticky dropped-event flag (see macro above)
//   o_dbg_state  : current FSM state (blink_state_t encoding)
// -----------------------------------------------------------------------------
module pulse_blinker
  import pulse_blinker_pkg::*;
#(
  parameter logic active_value = 1'b1,
  parameter int   on_cycles    = 12500000,
  parameter int   gap_cycles   = 12500000,
  parameter int   max_pending  = 15,
  parameter int   pbits        = $clog2(max_pending + 1),
  parameter int   cbits        = calc_cbits(on_cycles, gap_cycles)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_pulse,
  output logic             o_led,
  output logic             o_busy,
  output logic [pbits-1:0] o_pending,
  output logic             o_overflow,
  output logic [1:0]       o_dbg_state
);

  localparam logic [cbits-1:0] on_lim  = cbits'(on_cycles - 1);
  localparam logic [cbits-1:0] gap_lim = cbits'(gap_cycles - 1);
  localparam logic [pbits-1:0] pmax    = pbits'(max_pending);

  blink_state_t     state_q, state_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic [pbits-1:0] pending_q, pending_d;

  logic             timer_clear;
  logic [cbits-1:0] timer_limit;
  logic             expire;
  logic             consume;   // a queued event starts the next blink
  logic             direct;    // live pulse on the final GAP cycle starts it
  logic             accept;    // pulse that goes into the queue
  logic             saturated;

  assign timer_limit = (state_q == GAP) ? gap_lim : on_lim;

  blink_timer #(
    .cbits(cbits)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .limit  (timer_limit),
    .expire (expire)
  );

  // Next-state logic. The timer is held at 0 in IDLE so the first ON cycle
  // always sees count 0; every phase change clears it again.
  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    consume     = 1'b0;
    direct      = 1'b0;
    case (state_q)
      IDLE: begin
        timer_clear = 1'b1;
        if (i_pulse) begin
          state_d = ON;
        end
      end
      ON: begin
        if (expire) begin
          state_d     = GAP;
          timer_clear = 1'b1;
        end
      end
      GAP: begin
        if (expire) begin
          timer_clear = 1'b1;
          if (pending_q != '0) begin
            state_d = ON;
            consume = 1'b1;
          end else if (i_pulse) begin
            state_d = ON;
            direct  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        timer_clear = 1'b1;
      end
    endcase
  end

  // Pending counter. A pulse used directly on the last GAP cycle never
  // enters the queue; simultaneous add and consume cancel out, which also
  // means a saturated queue drops nothing in that cycle.
  assign accept    = i_pulse && (state_q != IDLE) && !direct;
  assign saturated = (pending_q == pmax);

  always_comb begin
    pending_d = pending_q;
    if (accept && !consume) begin
      if (!saturated) begin
        pending_d = pending_q + pbits'(1);
      end
    end else if (!accept && consume) begin
      pending_d = pending_q - pbits'(1);
    end
  end

  // Outputs are registered from the next state so o_led/o_busy line up with
  // the state they describe.
  always_comb begin
    led_d  = (state_d == ON) ? active_value : ~active_value;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      led_q     <= ~active_value;
      busy_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

`ifdef PULSE_BLINKER_OVERFLOW_EN
  logic drop;
  logic overflow_q, overflow_d;

  assign drop = accept && !consume && saturated;

  always_comb begin
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_led       = led_q;
  assign o_busy      = busy_q;
  assign o_pending   = pending_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_pulse_blinker.sv
// -----------------------------------------------------------------------------
// tb_pulse_blinker
// Directed bench for pulse_blinker with on_cycles=4, gap_cycles=3,
// max_pending=3. A second instance with active_value=0 shares the stimulus.
// Cycle k is the interval after the k-th rising edge following reset release;
// inputs set in cycle k are sampled at edge k+1, outputs are read 1ns after
// each edge. Build with PULSE_BLINKER_OVERFLOW_EN to expect the sticky flag.
// -----------------------------------------------------------------------------
module tb_pulse_blinker;
  import pulse_blinker_pkg::*;

`ifdef PULSE_BLINKER_OVERFLOW_EN
  localparam bit ov_en = 1'b1;
`else
  localparam bit ov_en = 1'b0;
`endif

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_pulse = 1'b0;
  always #5 clk = ~clk;

  logic       o_led, o_busy, o_overflow;
  logic [1:0] o_pending;
  logic [1:0] o_dbg_state;
  logic       inv_led, inv_busy, inv_overflow;
  logic [1:0] inv_pending;
  logic [1:0] inv_dbg_state;

  pulse_blinker #(
    .active_value(1'b1), .on_cycles(4), .gap_cycles(3), .max_pending(3)
  ) u_dut (
    .clk(clk), .rst(rst), .i_pulse(i_pulse), .o_led(o_led), .o_busy(o_busy),
    .o_pending(o_pending), .o_overflow(o_overflow), .o_dbg_state(o_dbg_state)
  );

  pulse_blinker #(
    .active_value(1'b0), .on_cycles(4), .gap_cycles(3), .max_pending(3)
  ) u_dut_inv (
    .clk(clk), .rst(rst), .i_pulse(i_pulse), .o_led(inv_led), .o_busy(inv_busy),
    .o_pending(inv_pending), .o_overflow(inv_overflow), .o_dbg_state(inv_dbg_state)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  logic [W-1:0] exp_q[$];

  // driver tasks
  task automatic tick(input logic p);
    i_pulse = p;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_led !== 1'b0) $display("FAIL reset_led got=%b exp=0", o_led); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else passed++;
    total++; if (o_pending !== 2'd0) $display("FAIL reset_pending got=%0d exp=0", o_pending); else passed++;
    total++; if (o_overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", o_overflow); else passed++;
    total++; if (inv_led !== 1'b1) $display("FAIL reset_inv_led got=%b exp=1", inv_led); else passed++;
    total++; if (o_dbg_state !== 2'(IDLE)) $display("FAIL reset_state got=%0d exp=0", o_dbg_state); else passed++;
  endtask

  task automatic test_single_pulse();
    logic el, eb;
    do_reset();
    for (int c = 0; c <= 21; c++) begin
      tick(c == 10);
      el = (cyc >= 11 && cyc <= 14);
      eb = (cyc >= 11 && cyc <= 17);
      total++; if (o_led !== el) $display("FAIL single_led cyc=%0d got=%b exp=%b", cyc, o_led, el); else passed++;
      total++; if (inv_led !== ~el) $display("FAIL single_inv_led cyc=%0d got=%b exp=%b", cyc, inv_led, ~el); else passed++;
      total++; if (o_busy !== eb) $display("FAIL single_busy cyc=%0d got=%b exp=%b", cyc, o_busy, eb); else passed++;
      total++; if (o_pending !== 2'd0) $display("FAIL single_pending cyc=%0d got=%0d exp=0", cyc, o_pending); else passed++;
    end
  endtask

  task automatic test_queued();
    logic el, eb;
    int ep;
    do_reset();
    for (int c = 0; c <= 34; c++) begin
      tick(c == 10 || c == 12 || c == 13);
      el = (cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21) || (cyc >= 25 && cyc <= 28);
      eb = (cyc >= 11 && cyc <= 31);
      ep = int'(cyc >= 13) + int'(cyc >= 14) - int'(cyc >= 18) - int'(cyc >= 25);
      total++; if (o_led !== el) $display("FAIL queued_led cyc=%0d got=%b exp=%b", cyc, o_led, el); else passed++;
      total++; if (o_busy !== eb) $display("FAIL queued_busy cyc=%0d got=%b exp=%b", cyc, o_busy, eb); else passed++;
      total++; if (o_pending !== 2'(ep)) $display("FAIL queued_pending cyc=%0d got=%0d exp=%0d", cyc, o_pending, ep); else passed++;
    end
  endtask

  task automatic test_overflow();
    logic prev_led;
    logic eo;
    logic [W-1:0] exp_start;
    int ep;
    do_reset();
    exp_q.delete();
    exp_q.push_back(W'(11));
    exp_q.push_back(W'(18));
    exp_q.push_back(W'(25));
    exp_q.push_back(W'(32));
    prev_led = o_led;
    for (int c = 0; c <= 44; c++) begin
      tick(c >= 10 && c <= 14);
      ep = int'(cyc >= 12) + int'(cyc >= 13) + int'(cyc >= 14)
         - int'(cyc >= 18) - int'(cyc >= 25) - int'(cyc >= 32);
      eo = ov_en && (cyc >= 15);
      total++; if (o_pending !== 2'(ep)) $display("FAIL ovf_pending cyc=%0d got=%0d exp=%0d", cyc, o_pending, ep); else passed++;
      total++; if (o_overflow !== eo) $display("FAIL ovf_flag cyc=%0d got=%b exp=%b", cyc, o_overflow, eo); else passed++;
      if (o_led && !prev_led) begin
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL ovf_extra_blink cyc=%0d got=start exp=none", cyc);
        end else begin
          exp_start = exp_q.pop_front();
          if (W'(cyc) !== exp_start) $display("FAIL ovf_blink_start got=%0d exp=%0d", cyc, exp_start);
          else passed++;
        end
      end
      prev_led = o_led;
    end
    total++; if (exp_q.size() != 0) $display("FAIL ovf_blink_count got=%0d_missing exp=0_missing", exp_q.size()); else passed++;
    total++; if (o_busy !== 1'b0) $display("FAIL ovf_idle_end got=%b exp=0", o_busy); else passed++;
  endtask

  task automatic test_last_gap_pulse();
    logic el, eb;
    logic [1:0] es;
    do_reset();
    for (int c = 0; c <= 27; c++) begin
      tick(c == 10 || c == 17);
      el = (cyc >= 11 && cyc <= 14) || (cyc >= 18 && cyc <= 21);
      eb = (cyc >= 11 && cyc <= 24);
      es = el ? 2'(ON) : (eb ? 2'(GAP) : 2'(IDLE));
      total++; if (o_led !== el) $display("FAIL lastgap_led cyc=%0d got=%b exp=%b", cyc, o_led, el); else passed++;
      total++; if (o_busy !== eb) $display("FAIL lastgap_busy cyc=%0d got=%b exp=%b", cyc, o_busy, eb); else passed++;
      total++; if (o_dbg_state !== es) $display("FAIL lastgap_state cyc=%0d got=%0d exp=%0d", cyc, o_dbg_state, es); else passed++;
      total++; if (o_pending !== 2'd0) $display("FAIL lastgap_pending cyc=%0d got=%0d exp=0", cyc, o_pending); else passed++;
    end
  endtask

  task automatic test_mid_reset();
    logic el, eb;
    int ep;
    do_reset();
    for (int c = 0; c <= 35; c++) begin
      rst = (c == 13);
      tick(c == 10 || c == 11 || c == 12);
      rst = 1'b0;
      el = (cyc >= 11 && cyc <= 13);
      eb = (cyc >= 11 && cyc <= 13);
      ep = (cyc <= 13) ? (int'(cyc >= 12) + int'(cyc >= 13)) : 0;
      total++; if (o_led !== el) $display("FAIL midrst_led cyc=%0d got=%b exp=%b", cyc, o_led, el); else passed++;
      total++; if (o_busy !== eb) $display("FAIL midrst_busy cyc=%0d got=%b exp=%b", cyc, o_busy, eb); else passed++;
      total++; if (o_pending !== 2'(ep)) $display("FAIL midrst_pending cyc=%0d got=%0d exp=%0d", cyc, o_pending, ep); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_queued();
    test_overflow();
    test_last_gap_pulse();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
